// File: rtl/piano_pkg.sv
// Shared piano-controller types: event codes, event record, default debounce length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piano_pkg;
    localparam int NUM_KEYS      = 8;
    localparam int NUM_IN        = 10;
    localparam int DB_CYCLES_DEF = 1000000;

    localparam logic [3:0] EV_MODE_SW = 4'd8;
    localparam logic [3:0] EV_CONFIRM = 4'd9;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } ev_t;
endpackage

// File: rtl/key_event_encoder_if.sv
// Key event stream: valid/ready handshake carrying one event code and direction.
// Latency: n/a (wires only).
// Backpressure: producer holds code/press while valid && !ready.
interface key_event_encoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_code;
    logic       ev_press;

    modport master (output ev_valid, output ev_code, output ev_press, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_press, output ev_ready);
endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO, power-of-two depth, registered pointers.
// Latency: push visible at pop side the cycle after it is accepted.
// Backpressure: push_rdy low only when full and no pop this cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign pop_vld  = (cnt_q != '0);
    assign pop_dat  = mem_q[rptr_q];
    assign do_pop   = pop_vld && pop_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_rdy = (cnt_q != FULL_CNT) || do_pop;
    assign do_push  = push_vld && push_rdy;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = push_dat;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/key_debounce.sv
// One input: 2-flop synchronizer, stability counter, debounced level, registered edge event.
// Latency: level changes DB_CYCLES+2 edges after a clean raw change; event pulses with it.
// Backpressure: none; evt_vld is a single-cycle pulse.
module key_debounce #(
    parameter int DB_CYCLES = 4,
    parameter bit REL_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic evt_vld,
    output logic evt_press
);
    localparam int                CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             evt_vld_q, evt_vld_d;
    logic             evt_press_q, evt_press_d;

    always_comb begin
        sync_d   = {sync_q[0], raw_in};
        stable_d = stable_q;
        cnt_d    = '0;
        // Counter only runs while the synced level disagrees; any agreement restarts it.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        evt_vld_d   = (stable_d != stable_q) && (stable_d || REL_EN);
        evt_press_d = stable_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            stable_q    <= 1'b0;
            evt_vld_q   <= 1'b0;
            evt_press_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            evt_vld_q   <= evt_vld_d;
            evt_press_q <= evt_press_d;
        end
    end

    assign level     = stable_q;
    assign evt_vld   = evt_vld_q;
    assign evt_press = evt_press_q;
endmodule

// File: rtl/key_event_encoder.sv
// Debounces 8 piano keys + 2 buttons and queues press (and, with KEY_RELEASE_EV_EN, key release) events.
// Latency: ev_valid rises 2 cycles after key_level changes when the queue is idle.
// Backpressure: events wait in per-input pending flags while the FIFO is full; re-edge while pending sets overflow.
module key_event_encoder
    import piano_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_KEYS-1:0]    key_board_in,
    input  logic                   mode_switch_btn,
    input  logic                   confirm_btn,
    key_event_encoder_if.master    ev_if,
    output logic [NUM_KEYS-1:0]    key_level,
    output logic                   overflow
);
`ifdef KEY_RELEASE_EV_EN
    localparam bit KEY_REL_EN = 1'b1;
`else
    localparam bit KEY_REL_EN = 1'b0;
`endif

    logic [NUM_IN-1:0] raw_in, evt_vld, evt_press;
    logic [1:0]        btn_lvl_unused;
    logic [NUM_IN-1:0] pend_q, pend_d, dir_q, dir_d;
    logic              ovf_q, ovf_d;
    logic              sel_vld, sel_press;
    logic [3:0]        sel_idx;
    logic              push_rdy, head_vld;
    ev_t               push_dat, head;

    assign raw_in = {confirm_btn, mode_switch_btn, key_board_in};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_db
        key_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .REL_EN    ((i < NUM_KEYS) ? KEY_REL_EN : 1'b0)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .raw_in    (raw_in[i]),
            .level     (),
            .evt_vld   (evt_vld[i]),
            .evt_press (evt_press[i])
        );
        if (i < NUM_KEYS) begin : g_key
            assign key_level[i] = u_db.level;
        end else begin : g_btn
            assign btn_lvl_unused[i-NUM_KEYS] = u_db.level;
        end
    end

    // Lowest index wins: keys 0-7, then mode switch, then confirm.
    always_comb begin
        sel_vld   = 1'b0;
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_vld   = 1'b1;
                sel_idx   = 4'(i);
                sel_press = dir_q[i];
            end
        end
    end

    assign push_dat = '{code: sel_idx, press: sel_press};

    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        ovf_d  = ovf_q;
        if (sel_vld && push_rdy) begin
            pend_d[sel_idx] = 1'b0;
        end
        // An edge landing on a flag that was not drained this cycle replaces the older event.
        for (int i = 0; i < NUM_IN; i++) begin
            if (evt_vld[i]) begin
                ovf_d     = ovf_d | pend_d[i];
                pend_d[i] = 1'b1;
                dir_d[i]  = evt_press[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
            dir_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dir_q  <= dir_d;
            ovf_q  <= ovf_d;
        end
    end

    fifo #(
        .WIDTH ($bits(ev_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (sel_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (head_vld),
        .pop_dat  (head),
        .pop_rdy  (ev_if.ev_ready)
    );

    assign ev_if.ev_valid = head_vld;
    assign ev_if.ev_code  = head_vld ? head.code : 4'd0;
    assign ev_if.ev_press = head_vld & head.press;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus random key/button/ready traffic vs an event-level model.
module tb_key_event_encoder;
    import piano_pkg::*;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int NI    = 10;
`ifdef KEY_RELEASE_EV_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_board_in;
    logic       mode_switch_btn, confirm_btn;
    logic [7:0] key_level;
    logic       overflow;

    key_event_encoder_if ev_if();

    key_event_encoder #(.DB_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_board_in    (key_board_in),
        .mode_switch_btn (mode_switch_btn),
        .confirm_btn     (confirm_btn),
        .ev_if           (ev_if),
        .key_level       (key_level),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int vld_cycles = 0;
    logic [4:0] dut_log [$];

    // Model: raw sample history, accepted levels, pending events, event queue.
    bit m_hist [NI][DB+1];
    bit m_stab [NI];
    bit m_evt  [NI];
    bit m_evp  [NI];
    bit m_pend [NI];
    bit m_dir  [NI];
    bit m_ovf;
    logic [4:0] m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [4:0] exp);
        n_chk++;
        if (idx >= 0 && idx < dut_log.size() && dut_log[idx] === exp) n_pass++;
        else $display("FAIL %s: got %0h (log size %0d) expected %0h", name,
                      (idx >= 0 && idx < dut_log.size()) ? dut_log[idx] : 5'h1f, dut_log.size(), exp);
    endtask

    task automatic model_step();
        logic [NI-1:0] raw;
        bit pop, flip;
        int sel;
        raw = {confirm_btn, mode_switch_btn, key_board_in};
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_stab[i] = 0; m_evt[i] = 0; m_evp[i] = 0; m_pend[i] = 0; m_dir[i] = 0;
                for (int k = 0; k <= DB; k++) m_hist[i][k] = 0;
            end
            m_q.delete();
            m_ovf = 0;
            return;
        end
        pop = (m_q.size() > 0) && ev_if.ev_ready;
        if (pop) void'(m_q.pop_front());
        sel = -1;
        for (int i = 0; i < NI; i++) if (m_pend[i] && sel < 0) sel = i;
        if (sel >= 0 && m_q.size() < DEPTH) begin
            m_q.push_back({4'(sel), m_dir[sel]});
            m_pend[sel] = 0;
        end
        for (int i = 0; i < NI; i++) begin
            if (m_evt[i]) begin
                if (m_pend[i]) m_ovf = 1;
                m_pend[i] = 1;
                m_dir[i]  = m_evp[i];
            end
        end
        // Level accepted once the last DB synchronized samples (2 edges old) all disagree with it.
        for (int i = 0; i < NI; i++) begin
            flip = 1;
            for (int k = 1; k <= DB; k++) if (m_hist[i][k] == m_stab[i]) flip = 0;
            m_evt[i] = 0;
            if (flip) begin
                m_stab[i] = !m_stab[i];
                m_evt[i]  = m_stab[i] || (REL && i < 8);
                m_evp[i]  = m_stab[i];
            end
            for (int k = DB; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = raw[i];
        end
    endtask

    task automatic compare();
        logic [7:0] lv;
        for (int i = 0; i < 8; i++) lv[i] = m_stab[i];
        chk("ev_valid", ev_if.ev_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("ev_code", ev_if.ev_code, m_q[0][4:1]);
            chk("ev_press", ev_if.ev_press, m_q[0][0]);
        end
        chk("key_level", key_level, lv);
        chk("overflow", overflow, m_ovf);
        if (ev_if.ev_valid) vld_cycles++;
    endtask

    task automatic tick();
        if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1)
            dut_log.push_back({ev_if.ev_code, ev_if.ev_press});
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic settle();
        key_board_in = '0; mode_switch_btn = 0; confirm_btn = 0; ev_if.ev_ready = 1;
        run(25);
        dut_log.delete();
        vld_cycles = 0;
    endtask

    initial begin
        key_board_in = '0; mode_switch_btn = 0; confirm_btn = 0; ev_if.ev_ready = 0; rst = 0;
        run(3);
        chk("rst_ev_valid", ev_if.ev_valid, 0);
        chk("rst_ev_code", ev_if.ev_code, 0);
        chk("rst_ev_press", ev_if.ev_press, 0);
        chk("rst_key_level", key_level, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1;
        settle();

        // Key 3 held 10 cycles with consumer ready.
        key_board_in[3] = 1; run(10);
        key_board_in[3] = 0; run(20);
        chk("s1_count", dut_log.size(), REL ? 2 : 1);
        chk_log("s1_first", 0, {4'd3, 1'b1});
        chk_log("s1_last", dut_log.size() - 1, REL ? {4'd3, 1'b0} : {4'd3, 1'b1});
        chk("s1_vld_cycles", vld_cycles, REL ? 2 : 1);
        settle();

        // Key 5 bouncing faster than the debounce window.
        for (int k = 0; k < 10; k++) begin
            key_board_in[5] = ~key_board_in[5]; run(2);
        end
        key_board_in[5] = 0; run(10);
        chk("s2_no_event", dut_log.size(), 0);
        chk("s2_level5", key_level[5], 0);
        settle();

        // Keys 1, 6 and confirm simultaneously, consumer stalled.
        ev_if.ev_ready = 0;
        key_board_in[1] = 1; key_board_in[6] = 1; confirm_btn = 1;
        run(12);
        chk("s3_head_valid", ev_if.ev_valid, 1);
        chk("s3_head_code", ev_if.ev_code, 1);
        ev_if.ev_ready = 1;
        run(3);
        chk("s3_drained", ev_if.ev_valid, 0);
        chk("s3_count", dut_log.size(), 3);
        chk_log("s3_e0", 0, {4'd1, 1'b1});
        chk_log("s3_e1", 1, {4'd6, 1'b1});
        chk_log("s3_e2", 2, {4'd9, 1'b1});
        settle();

        // All eight keys while stalled: 4 queued, 4 pending, nothing lost.
        ev_if.ev_ready = 0;
        key_board_in = 8'hFF;
        run(15);
        chk("s4_overflow", overflow, 0);
        chk("s4_head", ev_if.ev_code, 0);
        ev_if.ev_ready = 1;
        run(10);
        chk("s4_count", dut_log.size(), 8);
        for (int i = 0; i < 8; i++) chk_log("s4_order", i, {4'(i), 1'b1});
        settle();

        // Key 2 press then release.
        key_board_in[2] = 1; run(8);
        key_board_in[2] = 0; run(12);
        chk("s5_count", dut_log.size(), REL ? 2 : 1);
        chk_log("s5_press", 0, {4'd2, 1'b1});
        chk_log("s5_last", dut_log.size() - 1, REL ? {4'd2, 1'b0} : {4'd2, 1'b1});
        settle();

        // Second edge on key 4 while its first event is still pending.
        ev_if.ev_ready = 0;
        key_board_in[4:0] = 5'h1F; run(12);
        chk("s6_no_ovf_yet", overflow, 0);
        key_board_in[4] = 0; run(8);
        key_board_in[4] = 1; run(10);
        chk("s6_overflow", overflow, 1);
        ev_if.ev_ready = 1; run(10);
        chk("s6_count", dut_log.size(), 5);
        chk_log("s6_key4", 4, {4'd4, 1'b1});
        settle();

        // Reset while three events are queued, keys held through it.
        ev_if.ev_ready = 0;
        key_board_in[2:0] = 3'h7; run(12);
        chk("s7_queued", ev_if.ev_valid, 1);
        chk("s7_sticky_ovf", overflow, 1);
        rst = 0; tick();
        chk("s7_rst_valid", ev_if.ev_valid, 0);
        chk("s7_rst_ovf", overflow, 0);
        chk("s7_rst_level", key_level, 0);
        rst = 1; ev_if.ev_ready = 1; run(20);
        chk("s7_count", dut_log.size(), 3);
        chk_log("s7_e2", 2, {4'd2, 1'b1});
        settle();

        // Random traffic: slow-ish toggles with bounce, phases of light and heavy backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) if ($urandom_range(15) == 0) key_board_in[i] = ~key_board_in[i];
            if ($urandom_range(15) == 0) mode_switch_btn = ~mode_switch_btn;
            if ($urandom_range(15) == 0) confirm_btn = ~confirm_btn;
            if ((c / 200) % 2 == 0) ev_if.ev_ready = ($urandom_range(9) < 8);
            else                    ev_if.ev_ready = ($urandom_range(9) < 2);
            rst = ($urandom_range(999) != 0);
            tick();
        end
        rst = 1;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept an input level (10 ms at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries, power of two, 2..16.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port key_board_in  in  8  raw asynchronous piano keys, bit i = note i, 1 = pressed.
REQ-006 SHALL have port mode_switch_btn  in  1  raw asynchronous mode-cycle button, 1 = pressed.
REQ-007 SHALL have port confirm_btn  in  1  raw asynchronous mode-confirm button, 1 = pressed.
REQ-008 SHALL have port ev_valid  out  1  head event present.
REQ-009 SHALL have port ev_ready  in  1  consumer (mode FSM) accepts head event.
REQ-010 SHALL have port ev_code  out  4  0-7 note index, 8 mode switch, 9 confirm.
REQ-011 SHALL have port ev_press  out  1  1 press, 0 release.
REQ-012 SHALL have port key_level  out  8  debounced key levels, feeding free-play tone generation.
REQ-013 SHALL have port overflow  out  1  sticky: an event was lost.

Function
REQ-014 SHALL pass each of the 10 raw inputs through a 2-flop synchronizer before any other use.
REQ-015 SHALL keep per input a stable level and a counter: synced == stable clears the counter; otherwise the counter increments, and at count DB_CYCLES-1 stable takes the synced value and the counter clears.
REQ-016 SHALL raise a one-cycle edge on a stable-level change: 0->1 press, 1->0 release; buttons produce press edges only.
REQ-017 SHALL record each edge in a per-input pending flag plus direction on the cycle after the stable change.
REQ-018 SHALL each cycle move the lowest-indexed pending input (keys 0-7, then 8 switch, then 9 confirm) into the FIFO if not full, clearing its flag; at most one push per cycle.
REQ-019 SHALL, with FIFO full, keep pending flags set (no loss) until a pop frees space.
REQ-020 SHALL, when an edge arrives on an input whose pending flag is still set, overwrite the direction and set overflow.
REQ-021 SHALL drive ev_valid = FIFO non-empty and ev_code/ev_press = head entry; pop occurs on ev_valid && ev_ready.
REQ-022 SHALL hold ev_code/ev_press stable while ev_valid && !ev_ready.
REQ-023 SHALL support push and pop in the same cycle when full or non-empty, occupancy unchanged.
REQ-024 SHALL assert ev_valid exactly 2 cycles after key_level changes, given an empty FIFO and no other pending input.
REQ-025 SHALL drive key_level directly from the stable registers of inputs 0-7.

Reset
REQ-026 SHALL, when rst is low on a clk edge, clear synchronizers, counters, stable levels, pending flags, FIFO pointers and overflow; ev_valid=0, ev_code=0, ev_press=0, key_level=0.
REQ-027 SHALL discard in-flight and queued events on reset mid-operation; inputs held pressed through reset generate a press event after DB_CYCLES+2 cycles post-release of reset.

Configuration
REQ-028 SHALL, with KEY_RELEASE_EV_EN defined, queue key release events with ev_press=0.
REQ-029 SHALL, without KEY_RELEASE_EV_EN, generate no release events and tie ev_press to 1; key_level still tracks releases.

Structure
REQ-030 SHALL take from shared package piano_pkg: EV_MODE_SW=8, EV_CONFIRM=9, event struct {code[3:0], press}, default DB_CYCLES.
REQ-031 SHALL instantiate sub-module key_debounce (synchronizer + counter + stable level + edge) once per input, 10 instances.

Verification (bench uses DB_CYCLES=4, FIFO_DEPTH=4)
REQ-032 SHALL check: key 3 held high 10 cycles, ev_ready=1 -> one event code=3 press=1; ev_valid high 1 cycle.
REQ-033 SHALL check: key 5 toggles every 2 cycles for 20 cycles, then held low -> no event, key_level[5]=0.
REQ-034 SHALL check: keys 1 and 6 and confirm rise same cycle, ev_ready=0 -> FIFO holds 1,6,9 in order; ready=1 drains them one per cycle.
REQ-035 SHALL check: ev_ready=0, keys 0-7 pressed -> 4 queued, 4 pending, overflow=0; ready=1 -> all 8 delivered in index order.
REQ-036 SHALL check: key 2 pressed, then released with KEY_RELEASE_EV_EN on -> events (2,1),(2,0); macro off -> only (2,1).
REQ-037 SHALL check: rst low 1 cycle while 3 events are queued -> ev_valid=0 next cycle, overflow=0, key_level=0.
